// File: rtl/seq_magnitude_comparator.sv
// Sequential magnitude comparator: compares two N-bit operands MSB-first,
// DIGIT bits per clock, with a start/busy/done handshake, signed/unsigned
// mode, an eq/gt cascade from a more-significant stage and optional early exit.
//
// Handshake: start is sampled only in IDLE; once accepted, busy is high for
// every RUN cycle, and done pulses for exactly one cycle with eq_out/gt_out/
// lt_out valid in that same cycle. The result outputs hold until the next done.
// A start seen while busy or while done is high is dropped, not queued.
module seq_magnitude_comparator #(
  parameter int N          = 8,
  parameter int DIGIT      = 2,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  input  logic         eq_in,
  input  logic         gt_in,
  output logic         busy,
  output logic         done,
  output logic         eq_out,
  output logic         gt_out,
  output logic         lt_out
);

  localparam int STEPS = (N + DIGIT - 1) / DIGIT;
  localparam int W     = STEPS * DIGIT;
  localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     a_ext;
  logic [W-1:0]     b_ext;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             res_gt;
  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic             dec_now;
  logic             gt_now;
  logic             last;

  // Pad operands to a whole number of digits; in signed mode sign-extend and
  // flip the top bit so a plain unsigned digit compare orders two's complement.
  always_comb begin
    a_ext = W'(a);
    b_ext = W'(b);
    for (int i = N; i < W; i++) begin
      a_ext[i] = signed_mode & a[N-1];
      b_ext[i] = signed_mode & b[N-1];
    end
    a_ext[W-1] = a_ext[W-1] ^ signed_mode;
    b_ext[W-1] = b_ext[W-1] ^ signed_mode;
  end

  // Current digit sits at the top of the shifting operand registers; the
  // first differing digit latches the decision and later digits are ignored.
  always_comb begin
    da      = a_r[W-1 -: DIGIT];
    db      = b_r[W-1 -: DIGIT];
    dec_now = decided | (da != db);
    gt_now  = decided ? res_gt : (da > db);
    last    = (idx == '0) || (EARLY_EXIT && dec_now);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      eq_out  <= 1'b0;
      gt_out  <= 1'b0;
      lt_out  <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      res_gt  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a_ext;
            b_r     <= b_ext;
            idx     <= IW'(STEPS - 1);
            decided <= 1'b0;
            res_gt  <= 1'b0;
            if (!eq_in) begin
              // Cascade from a more-significant stage settles the result; skip the scan.
              state  <= DONE;
              done   <= 1'b1;
              eq_out <= 1'b0;
              gt_out <= gt_in;
              lt_out <= ~gt_in;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          a_r     <= a_r << DIGIT;
          b_r     <= b_r << DIGIT;
          idx     <= idx - 1'b1;
          decided <= dec_now;
          res_gt  <= gt_now;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            eq_out <= ~dec_now;
            gt_out <= dec_now & gt_now;
            lt_out <= dec_now & ~gt_now;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: five instances with different
// N/DIGIT/EARLY_EXIT, a driver issuing compares, and a monitor that pops a
// scoreboard queue on every done and checks result and latency.
module tb_seq_magnitude_comparator;

  // Instance configuration: 0:N8/D2/EE, 1:N8/D2/no-EE, 2:N7/D2/EE,
  // 3:N8/D3/EE, 4:N5/D5/no-EE.
  function automatic int n_of(input int i);
    case (i)
      2:       return 7;
      4:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int d_of(input int i);
    case (i)
      3:       return 3;
      4:       return 5;
      default: return 2;
    endcase
  endfunction

  function automatic int ee_of(input int i);
    return (i == 1 || i == 4) ? 0 : 1;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;
  logic rst_edge;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  // ---------------- DUT instances ----------------
  logic [7:0] a_s   [5];
  logic [7:0] b_s   [5];
  logic       start_s[5];
  logic       sm_s  [5];
  logic       eqi_s [5];
  logic       gti_s [5];
  logic       busy_s[5];
  logic       done_s[5];
  logic       eq_s  [5];
  logic       gt_s  [5];
  logic       lt_s  [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int GN = n_of(g);
    seq_magnitude_comparator #(
      .N          (GN),
      .DIGIT      (d_of(g)),
      .EARLY_EXIT (ee_of(g) != 0)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_s[g]),
      .a           (a_s[g][GN-1:0]),
      .b           (b_s[g][GN-1:0]),
      .signed_mode (sm_s[g]),
      .eq_in       (eqi_s[g]),
      .gt_in       (gti_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .eq_out      (eq_s[g]),
      .gt_out      (gt_s[g]),
      .lt_out      (lt_s[g])
    );
  end

  // ---------------- scoreboard ----------------
  // entry: [29:14] start cycle, [13:11] instance, [10:8] {eq,gt,lt}, [7:0] latency
  logic [29:0] exp_q[$];
  int n_cmp;
  int n_fail;

  task automatic check(input string name, input int inst, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s inst=%0d actual=%0d expected=%0d at cycle %0d", name, inst, act, expv, cyc);
    end
  endtask

  // Reference model: compares the operand values as integers; latency from
  // the position of the first differing digit of the offset-binary value.
  function automatic logic [10:0] model(input int i, input logic [7:0] av, input logic [7:0] bv,
                                        input logic sm, input logic eqi, input logic gti);
    int n, d, steps, w, x, y, ox, oy, lat, dx, dy;
    logic [2:0] r;
    n     = n_of(i);
    d     = d_of(i);
    steps = (n + d - 1) / d;
    w     = steps * d;
    x     = int'(av) & ((1 << n) - 1);
    y     = int'(bv) & ((1 << n) - 1);
    if (sm) begin
      if (x >= (1 << (n - 1))) x = x - (1 << n);
      if (y >= (1 << (n - 1))) y = y - (1 << n);
    end
    if (!eqi) begin
      r   = gti ? 3'b010 : 3'b001;
      lat = 1;
    end else begin
      r   = (x == y) ? 3'b100 : ((x > y) ? 3'b010 : 3'b001);
      lat = steps + 1;
      if (ee_of(i) != 0) begin
        ox = x + (sm ? (1 << (w - 1)) : 0);
        oy = y + (sm ? (1 << (w - 1)) : 0);
        for (int j = 1; j <= steps; j++) begin
          dx = (ox >> (w - j * d)) % (1 << d);
          dy = (oy >> (w - j * d)) % (1 << d);
          if (lat == steps + 1 && dx != dy) lat = j + 1;
        end
      end
    end
    return {r, 8'(lat)};
  endfunction

  // ---------------- monitor ----------------
  logic [2:0]  prev_res [5];
  logic        prev_done[5];
  logic [2:0]  mon_r;
  logic [29:0] mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      mon_r = {eq_s[i], gt_s[i], lt_s[i]};
      if (done_s[i] === 1'b1) begin
        check("back_to_back_done", i, int'(prev_done[i] === 1'b1), 0);
        check("done_expected", i, int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("done_instance", i, i, int'(mon_e[13:11]));
          check("result_eq_gt_lt", i, int'(mon_r), int'(mon_e[10:8]));
          check("latency", i, cyc - int'(mon_e[29:14]) + 1, int'(mon_e[7:0]));
        end
      end else if (rst_edge === 1'b0) begin
        check("result_hold", i, int'(mon_r), int'(prev_res[i]));
      end
      prev_res[i]  = mon_r;
      prev_done[i] = done_s[i];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_cmp(input int i, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input logic eqi, input logic gti);
    logic [10:0] m;
    bit got;
    @(negedge clk);
    a_s[i]     = av;
    b_s[i]     = bv;
    sm_s[i]    = sm;
    eqi_s[i]   = eqi;
    gti_s[i]   = gti;
    start_s[i] = 1'b1;
    @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    m = model(i, av, bv, sm, eqi, gti);
    exp_q.push_back({16'(cyc), 3'(i), m});
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      // Captured values must be immune to later input changes.
      a_s[i]   = 8'($urandom);
      b_s[i]   = 8'($urandom);
      sm_s[i]  = 1'($urandom);
      eqi_s[i] = 1'($urandom);
      gti_s[i] = 1'($urandom);
      if (done_s[i] === 1'b1) begin
        got = 1;
        check("busy_at_done", i, int'(busy_s[i]), 0);
      end else begin
        check("busy_during_run", i, int'(busy_s[i]), int'(eqi));
      end
    end
    if (!got) check("done_timeout", i, 0, 1);
  endtask

  // Holds start high for h edges; every accepted start must complete once.
  task automatic hold_start(input int i, input logic [7:0] av, input logic [7:0] bv, input int h);
    logic [10:0] m;
    int p, c0;
    @(negedge clk);
    a_s[i]     = av;
    b_s[i]     = bv;
    sm_s[i]    = 1'b0;
    eqi_s[i]   = 1'b1;
    gti_s[i]   = 1'b0;
    start_s[i] = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    m  = model(i, av, bv, 1'b0, 1'b1, 1'b0);
    p  = int'(m[7:0]) + 1;
    for (int k = 0; k * p < h; k++) exp_q.push_back({16'(c0 + k * p), 3'(i), m});
    repeat (h - 1) @(posedge clk);
    #1;
    start_s[i] = 1'b0;
    repeat (20) @(negedge clk);
    check("held_start_all_done", i, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] ra;
  logic [7:0] rb;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_s[i] = '0; b_s[i] = '0; start_s[i] = 1'b0;
      sm_s[i] = 1'b0; eqi_s[i] = 1'b1; gti_s[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      check("reset_outputs", i, int'({busy_s[i], done_s[i], eq_s[i], gt_s[i], lt_s[i]}), 0);
    rst_n = 1'b1;

    // Directed cases
    do_cmp(0, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);  // equal, full scan
    do_cmp(0, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0);  // unsigned gt, early exit
    do_cmp(0, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);  // signed lt, early exit
    do_cmp(1, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0);  // no early exit
    do_cmp(1, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);
    do_cmp(0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);  // cascade pre-decided gt
    do_cmp(0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);  // cascade pre-decided lt
    do_cmp(2, 8'h7F, 8'h40, 1'b1, 1'b1, 1'b0);  // N=7 signed: -1 > -64
    do_cmp(2, 8'h3F, 8'h40, 1'b0, 1'b1, 1'b0);  // N=7 unsigned lt
    do_cmp(4, 8'h1F, 8'h10, 1'b1, 1'b1, 1'b0);  // single digit, signed

    // start held through busy and done
    hold_start(0, 8'h5A, 8'h3C, 10);

    // Reset in the middle of a compare: no done for the aborted request
    @(negedge clk);
    a_s[0] = 8'h00; b_s[0] = 8'h00; sm_s[0] = 1'b0; eqi_s[0] = 1'b1; start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_outputs", 0, int'({busy_s[0], done_s[0], eq_s[0], gt_s[0], lt_s[0]}), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_cmp(0, 8'hC3, 8'hC1, 1'b0, 1'b1, 1'b0);

    // Random sweep over all configurations
    for (int i = 0; i < 5; i++) begin
      repeat (30) begin
        ra = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
          default: rb = 8'($urandom);
        endcase
        do_cmp(i, ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
               1'($urandom_range(0, 1)));
      end
    end

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", 0, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
